// File: rtl/port_bridge.sv
// Memory-mapped CPU port bridging a 16-bit TX FIFO (CPU -> device) and RX FIFO
// (device -> CPU), with a status/control word at PORT_ADDR+1.
module port_bridge #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] PORT_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_write,
  input  logic        cpu_read,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] rx_word,
  output logic [15:0] status,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW        = AW + 1;
  localparam logic [CW-1:0]   FULL_CNT  = CW'(DEPTH);
  localparam logic [AW-1:0]   LAST_PTR  = AW'(DEPTH - 1);
  localparam logic [15:0]     CTRL_ADDR = PORT_ADDR + 16'd1;

  // Explicit wrap keeps pointer behaviour independent of DEPTH being a power of two.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + AW'(1);
  endfunction

  logic [15:0]   r_tx_mem [DEPTH];
  logic [AW-1:0] r_tx_rd;
  logic [AW-1:0] r_tx_wr;
  logic [CW-1:0] r_tx_cnt;

  logic [15:0]   r_rx_mem [DEPTH];
  logic [AW-1:0] r_rx_rd;
  logic [AW-1:0] r_rx_wr;
  logic [CW-1:0] r_rx_cnt;

  logic          r_tx_ovf;
  logic          r_rx_unf;

  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic w_data_wr, w_data_rd, w_ctrl_clr;
  logic w_tx_push, w_tx_pop, w_tx_ovf_evt;
  logic w_rx_push, w_rx_pop, w_rx_unf_evt;

  assign w_tx_full  = (r_tx_cnt == FULL_CNT);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == FULL_CNT);
  assign w_rx_empty = (r_rx_cnt == '0);

  assign w_data_wr  = cpu_write && (cpu_addr == PORT_ADDR);
  assign w_data_rd  = cpu_read  && (cpu_addr == PORT_ADDR);
  assign w_ctrl_clr = cpu_write && (cpu_addr == CTRL_ADDR) && cpu_wdata[0];

  // Fullness is judged on pre-edge state, so a same-cycle pop never rescues a write to a full TX.
  assign w_tx_push    = w_data_wr && !w_tx_full;
  assign w_tx_ovf_evt = w_data_wr &&  w_tx_full;
  assign w_tx_pop     = tx_valid  &&  tx_ready;

  assign w_rx_push    = rx_valid  &&  rx_ready;
  assign w_rx_pop     = w_data_rd && !w_rx_empty;
  assign w_rx_unf_evt = w_data_rd &&  w_rx_empty;

  assign tx_valid = !w_tx_empty;
  assign tx_data  = w_tx_empty ? 16'h0000 : r_tx_mem[r_tx_rd];
  assign rx_ready = !w_rx_full;
  assign rx_word  = w_rx_empty ? 16'h0000 : r_rx_mem[r_rx_rd];

  assign status = {4'(r_tx_cnt), 4'(r_rx_cnt), 2'b00, r_rx_unf, r_tx_ovf,
                   w_rx_full, w_tx_empty, w_tx_full, !w_rx_empty};

  // Storage holds no reset; validity is tracked by the counts alone.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= cpu_wdata;
    if (w_rx_push) r_rx_mem[r_rx_wr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_rd  <= '0;
      r_tx_wr  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= next_ptr(r_tx_wr);
      if (w_tx_pop)  r_tx_rd <= next_ptr(r_tx_rd);
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + CW'(1);
        2'b01:   r_tx_cnt <= r_tx_cnt - CW'(1);
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_rd  <= '0;
      r_rx_wr  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= next_ptr(r_rx_wr);
      if (w_rx_pop)  r_rx_rd <= next_ptr(r_rx_rd);
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + CW'(1);
        2'b01:   r_rx_cnt <= r_rx_cnt - CW'(1);
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  // A new error event outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_ovf <= 1'b0;
      r_rx_unf <= 1'b0;
    end else begin
      if (w_tx_ovf_evt)    r_tx_ovf <= 1'b1;
      else if (w_ctrl_clr) r_tx_ovf <= 1'b0;
      if (w_rx_unf_evt)    r_rx_unf <= 1'b1;
      else if (w_ctrl_clr) r_rx_unf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_port_bridge.sv
// Directed bench for port_bridge: TX/RX ordering through queues, status word,
// sticky flags, pointer wrap and reset flush.
module tb_port_bridge;

  localparam int          DEPTH = 4;
  localparam logic [15:0] P     = 16'h0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_write, cpu_read;
  logic [15:0] cpu_addr, cpu_wdata;
  logic [15:0] rx_word, status, tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;

  logic [15:0] tx_exp_q[$];
  logic [15:0] rx_exp_q[$];
  int          n_total  = 0;
  int          n_passed = 0;

  port_bridge #(.DEPTH(DEPTH), .PORT_ADDR(P)) dut (
    .clk(clk), .reset(reset),
    .cpu_write(cpu_write), .cpu_read(cpu_read),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .rx_word(rx_word), .status(status),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_write = 1'b0; cpu_read = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
    tx_ready  = 1'b0; rx_valid = 1'b0; rx_data  = 16'h0000;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_tx_head(input string tag);
    if (tx_exp_q.size() == 0) begin
      n_total++;
      $error("FAIL %s: tx queue empty, got %h", tag, tx_data);
    end else begin
      check(tag, tx_data, tx_exp_q.pop_front());
    end
  endtask

  task automatic check_rx_head(input string tag);
    if (rx_exp_q.size() == 0) begin
      n_total++;
      $error("FAIL %s: rx queue empty, got %h", tag, rx_word);
    end else begin
      check(tag, rx_word, rx_exp_q.pop_front());
    end
  endtask

  logic [15:0] v_tx, v_rx;

  initial begin
    idle();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    check("rst_status", status, 16'h0004);
    check("rst_tx_valid", {15'd0, tx_valid}, 16'd0);
    check("rst_tx_data", tx_data, 16'h0000);
    check("rst_rx_word", rx_word, 16'h0000);
    check("rst_rx_ready", {15'd0, rx_ready}, 16'd1);

    // Other addresses are ignored
    cpu_write = 1'b1; cpu_addr = P + 16'd2; cpu_wdata = 16'hFFFF;
    step(); idle();
    check("other_addr", status, 16'h0004);

    // Two writes, consumer stalled, then drained in consecutive cycles
    cpu_write = 1'b1; cpu_addr = P; cpu_wdata = 16'hA5A5; tx_exp_q.push_back(16'hA5A5);
    step();
    check("tx_latency_valid", {15'd0, tx_valid}, 16'd1);
    cpu_wdata = 16'h1234; tx_exp_q.push_back(16'h1234);
    step(); idle();
    check("two_wr_status", status, 16'h2000);
    tx_ready = 1'b1;
    check_tx_head("tx_first");
    step();
    check_tx_head("tx_second");
    step();
    check("tx_drained_valid", {15'd0, tx_valid}, 16'd0);
    idle();

    // Overflow: fifth write dropped, sticky flag, clear behaviour
    for (int i = 0; i < 5; i++) begin
      v_tx = 16'($urandom_range(0, 65535));
      cpu_write = 1'b1; cpu_addr = P; cpu_wdata = v_tx;
      if (i < DEPTH) tx_exp_q.push_back(v_tx);
      step();
    end
    idle();
    check("ovf_status", status, 16'h4012);
    cpu_write = 1'b1; cpu_addr = P + 16'd1; cpu_wdata = 16'h0000;
    step(); idle();
    check("clr_bit0_low", status, 16'h4012);
    cpu_write = 1'b1; cpu_addr = P + 16'd1; cpu_wdata = 16'h0001;
    step(); idle();
    check("ovf_cleared", status, 16'h4002);
    tx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check_tx_head("ovf_drain");
      step();
    end
    idle();
    check("ovf_drain_status", status, 16'h0004);

    // RX fill to full, then CPU pop while producer offers a fifth word
    for (int i = 1; i <= 4; i++) begin
      rx_valid = 1'b1; rx_data = 16'(i); rx_exp_q.push_back(16'(i));
      step();
    end
    idle();
    check("rx_full_ready", {15'd0, rx_ready}, 16'd0);
    check("rx_full_status", status, 16'h040D);
    cpu_read = 1'b1; cpu_addr = P + 16'd1;
    step(); idle();
    check("status_read_no_effect", status, 16'h040D);
    rx_valid = 1'b1; rx_data = 16'h0005;
    cpu_read = 1'b1; cpu_addr = P;
    check_rx_head("rx_pop_full");
    step();
    cpu_read = 1'b0;
    check("rx_after_pop_word", rx_word, 16'h0002);
    check("rx_stalled_push_status", status, 16'h0305);
    rx_exp_q.push_back(16'h0005);
    step(); idle();
    check("rx_push_after_stall", status, 16'h040D);
    cpu_read = 1'b1; cpu_addr = P;
    for (int i = 0; i < 4; i++) begin
      check_rx_head("rx_drain");
      step();
    end
    idle();
    check("rx_drained_status", status, 16'h0004);

    // Underflow: empty read sets rx_unf, pointers intact
    cpu_read = 1'b1; cpu_addr = P;
    step(); idle();
    check("unf_word", rx_word, 16'h0000);
    check("unf_status", status, 16'h0024);
    rx_valid = 1'b1; rx_data = 16'h7E57; rx_exp_q.push_back(16'h7E57);
    step(); idle();
    check_rx_head("unf_ptr_intact");
    // Clear racing a new underflow: error wins
    cpu_read = 1'b1; cpu_addr = P;
    step();
    cpu_read = 1'b1; cpu_write = 1'b1; cpu_addr = P + 16'd1; cpu_wdata = 16'h0001;
    step(); idle();
    check("unf_clear_ok", status, 16'h0004);
    cpu_read = 1'b1; cpu_addr = P;
    step();
    cpu_write = 1'b1; cpu_wdata = 16'h0001; cpu_addr = P;
    cpu_read = 1'b0;
    step(); idle();
    tx_exp_q.push_back(16'h0001);
    cpu_read = 1'b1; cpu_write = 1'b1; cpu_addr = P + 16'd1; cpu_wdata = 16'h0001;
    step(); idle();
    check("clear_vs_tx_word", status, 16'h1000);
    tx_ready = 1'b1;
    check_tx_head("tx_single");
    step(); idle();

    // Error wins over simultaneous clear (same address bus: write ctrl while read empty needs P)
    cpu_read = 1'b1; cpu_addr = P;
    step(); idle();
    check("unf_set_again", status, 16'h0024);

    // Pointer wrap: 3*DEPTH concurrent push/pop pairs on both FIFOs
    v_tx = 16'($urandom_range(0, 65535)); v_rx = 16'($urandom_range(0, 65535));
    cpu_write = 1'b1; cpu_addr = P; cpu_wdata = v_tx; rx_valid = 1'b1; rx_data = v_rx;
    tx_exp_q.push_back(v_tx); rx_exp_q.push_back(v_rx);
    step();
    for (int i = 0; i < 3 * DEPTH; i++) begin
      v_tx = 16'($urandom_range(0, 65535)); v_rx = 16'($urandom_range(0, 65535));
      cpu_write = 1'b1; cpu_read = 1'b1; cpu_addr = P; cpu_wdata = v_tx;
      tx_ready = 1'b1; rx_valid = 1'b1; rx_data = v_rx;
      check_tx_head("wrap_tx");
      check_rx_head("wrap_rx");
      check("wrap_status", status & 16'hFFDF, 16'h1101);
      tx_exp_q.push_back(v_tx); rx_exp_q.push_back(v_rx);
      step();
    end
    idle();
    tx_ready = 1'b1; cpu_read = 1'b1; cpu_addr = P;
    check_tx_head("wrap_tx_last");
    check_rx_head("wrap_rx_last");
    step(); idle();
    cpu_write = 1'b1; cpu_addr = P + 16'd1; cpu_wdata = 16'h0001;
    step(); idle();
    check("wrap_end_status", status, 16'h0004);

    // Reset mid-transfer flushes both FIFOs and beats a same-cycle write
    for (int i = 0; i < 3; i++) begin
      cpu_write = 1'b1; cpu_addr = P; cpu_wdata = 16'(16'h0A00 + i);
      rx_valid = 1'b1; rx_data = 16'(16'h0B00 + i);
      step();
    end
    idle();
    check("pre_reset_status", status, 16'h3301);
    reset = 1'b1; cpu_write = 1'b1; cpu_addr = P; cpu_wdata = 16'hBEEF;
    rx_valid = 1'b1; rx_data = 16'hCAFE;
    step();
    reset = 1'b0; idle();
    check("post_reset_status", status, 16'h0004);
    check("post_reset_tx_valid", {15'd0, tx_valid}, 16'd0);
    check("post_reset_rx_word", rx_word, 16'h0000);
    tx_exp_q.delete(); rx_exp_q.delete();

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
